// File: rtl/minbd_pkg.sv
// Shared definitions for the MinBD side-buffer slice: channel naming, flit
// field helpers and the slot priority encoder.
package minbd_pkg;

   typedef enum int {
      EAST  = 0,
      WEST  = 1,
      NORTH = 2,
      SOUTH = 3
   } chan_e;

   // The valid flag always sits in the top bit of a flit.
   function automatic int flit_valid_bit(input int flit_w);
      return flit_w - 1;
   endfunction

   // Index of the lowest set bit; returns 0 when nothing is set, so callers
   // must qualify the result with a reduction-OR of the same vector.
   function automatic int lowest_set(input logic [63:0] v);
      int idx;
      idx = 0;
      for (int i = 63; i >= 0; i--) begin
         if (v[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/minbd_sb_fifo.sv
// DEPTH-entry flit FIFO for the side buffer; the head is read combinationally
// so it can be reinjected in the same cycle it is selected.
module minbd_sb_fifo
   import minbd_pkg::*;
#(
   parameter int FLIT_W = 11,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [FLIT_W-1:0]          push_data,
   input  logic                       pop,
   output logic [FLIT_W-1:0]          head,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [FLIT_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr_reg;
   logic [PW-1:0]     rd_ptr_reg;
   logic [CW-1:0]     count_reg;
   logic [CW-1:0]     count_next;
   logic              full_reg;
   logic              empty_reg;
   logic              push_ok;
   logic              pop_ok;

   // A push into a full buffer is only accepted when a pop frees a slot.
   assign pop_ok  = pop && !empty_reg;
   assign push_ok = push && (!full_reg || pop_ok);

   always_comb begin
      count_next = count_reg;
      case ({push_ok, pop_ok})
         2'b10:   count_next = count_reg + CW'(1);
         2'b01:   count_next = count_reg - CW'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n && push_ok) mem[wr_ptr_reg] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         full_reg   <= 1'b0;
         empty_reg  <= 1'b1;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
         count_reg <= count_next;
         full_reg  <= (count_next == CW'(DEPTH));
         empty_reg <= (count_next == '0);
      end
   end

   assign head  = mem[rd_ptr_reg];
   assign count = count_reg;
   assign full  = full_reg;
   assign empty = empty_reg;

endmodule

// File: rtl/minbd_side_buffer.sv
// MinBD side buffer: absorbs one deflected flit per cycle, reinjects the
// buffered head into a free slot, and forces a swap when the head starves.
module minbd_side_buffer
   import minbd_pkg::*;
#(
   parameter int FLIT_W     = 11,
   parameter int NCH        = 4,
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NCH*FLIT_W-1:0]      flit_in,
   input  logic [NCH-1:0]             defl_in,
   output logic [NCH*FLIT_W-1:0]      flit_out,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty,
   output logic                       starve
);

   localparam int VB  = flit_valid_bit(FLIT_W);
   localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int WCW = $clog2(STARVE_MAX+1);

   logic [FLIT_W-1:0] in_ch    [NCH];
   logic [FLIT_W-1:0] out_next [NCH];
   logic [FLIT_W-1:0] out_reg  [NCH];
   logic [NCH-1:0]    valid;
   logic [NCH-1:0]    free_slots;
   logic [NCH-1:0]    cand;
   logic [IW-1:0]     free_idx;
   logic [IW-1:0]     cand_idx;
   logic [IW-1:0]     swap_idx;

   logic [WCW-1:0]    wait_reg;
   logic [WCW-1:0]    wait_next;
   logic              starve_reg;
   logic              starve_next;
   logic              starve_mode;

   logic              fifo_push;
   logic              fifo_pop;
   logic [FLIT_W-1:0] fifo_push_data;
   logic [FLIT_W-1:0] fifo_head;
   logic              fifo_full;
   logic              fifo_empty;

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         assign in_ch[gi] = flit_in[gi*FLIT_W +: FLIT_W];
         assign valid[gi] = in_ch[gi][VB];
         assign flit_out[gi*FLIT_W +: FLIT_W] = out_reg[gi];
      end
   endgenerate

   assign free_slots = ~valid;
   assign cand       = valid & defl_in;
   assign free_idx   = IW'(lowest_set(64'(free_slots)));
   assign cand_idx   = IW'(lowest_set(64'(cand)));
   assign swap_idx   = IW'(lowest_set(64'(valid)));

   // Forced swap only when the head has waited long enough and no slot is free.
   assign starve_mode = (wait_reg == WCW'(STARVE_MAX)) && !fifo_empty &&
                        (free_slots == '0);

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         out_next[i] = valid[i] ? in_ch[i] : '0;
      end
      fifo_push      = 1'b0;
      fifo_pop       = 1'b0;
      fifo_push_data = '0;
      starve_next    = 1'b0;

      if (starve_mode) begin
         fifo_push          = 1'b1;
         fifo_pop           = 1'b1;
         fifo_push_data     = in_ch[swap_idx];
         out_next[swap_idx] = fifo_head;
         starve_next        = 1'b1;
      end else begin
         // Free slots come from the inputs only, so a slot vacated by
         // buffering below can never receive the head in the same cycle.
         if (!fifo_empty && (|free_slots)) begin
            fifo_pop           = 1'b1;
            out_next[free_idx] = fifo_head;
         end
         if ((|cand) && (!fifo_full || fifo_pop)) begin
            fifo_push          = 1'b1;
            fifo_push_data     = in_ch[cand_idx];
            out_next[cand_idx] = '0;
         end
      end
   end

   always_comb begin
      wait_next = wait_reg;
      if (fifo_pop || fifo_empty) begin
         wait_next = '0;
      end else if (wait_reg != WCW'(STARVE_MAX)) begin
         wait_next = wait_reg + WCW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) out_reg[i] <= '0;
         wait_reg   <= '0;
         starve_reg <= 1'b0;
      end else begin
         for (int i = 0; i < NCH; i++) out_reg[i] <= out_next[i];
         wait_reg   <= wait_next;
         starve_reg <= starve_next;
      end
   end

   minbd_sb_fifo #(
      .FLIT_W (FLIT_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_data (fifo_push_data),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .count     (count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign full   = fifo_full;
   assign empty  = fifo_empty;
   assign starve = starve_reg;

endmodule

// File: tb/tb_minbd_side_buffer.sv
// Directed bench for minbd_side_buffer: a vector table for single-cycle
// behaviour plus hand-written multi-cycle sequences.
module tb_minbd_side_buffer;

   localparam int FLIT_W = 11;
   localparam int NCH    = 4;
   localparam int DEPTH  = 4;
   localparam int STARVE = 8;

   logic                  clk;
   logic                  rst_n;
   logic [NCH*FLIT_W-1:0] flit_in;
   logic [NCH-1:0]        defl_in;
   logic [NCH*FLIT_W-1:0] flit_out;
   logic [2:0]            count;
   logic                  full;
   logic                  empty;
   logic                  starve;

   int n_cmp = 0;
   int n_bad = 0;

   minbd_side_buffer #(
      .FLIT_W     (FLIT_W),
      .NCH        (NCH),
      .DEPTH      (DEPTH),
      .STARVE_MAX (STARVE)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flit_in  (flit_in),
      .defl_in  (defl_in),
      .flit_out (flit_out),
      .count    (count),
      .full     (full),
      .empty    (empty),
      .starve   (starve)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        r;
      logic [43:0] fin;
      logic [3:0]  defl;
      logic [43:0] exp_out;
      logic [2:0]  exp_cnt;
      logic        exp_full;
      logic        exp_empty;
      logic        exp_starve;
   } vec_t;

   vec_t vecs [8];

   function automatic logic [43:0] f4(input logic [10:0] e, input logic [10:0] w,
                                      input logic [10:0] n, input logic [10:0] s);
      return {s, n, w, e};
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h expected=%h", nm, got, exp);
      end
   endtask

   // One clock: drive inputs, take the edge, sample 1 time unit later, compare.
   task automatic apply(input string nm, input logic r, input logic [43:0] fin,
                        input logic [3:0] d, input logic [43:0] eo, input logic [2:0] ec,
                        input logic ef, input logic ee, input logic es);
      rst_n   = r;
      flit_in = fin;
      defl_in = d;
      @(posedge clk);
      #1;
      $display("%-14s rst_n=%b in=%h defl=%b -> out=%h cnt=%0d full=%b empty=%b starve=%b",
               nm, r, fin, d, flit_out, count, full, empty, starve);
      chk({nm, ".out"},    64'(flit_out), 64'(eo));
      chk({nm, ".count"},  64'(count),    64'(ec));
      chk({nm, ".full"},   64'(full),     64'(ef));
      chk({nm, ".empty"},  64'(empty),    64'(ee));
      chk({nm, ".starve"}, 64'(starve),   64'(es));
   endtask

   initial begin
      logic [10:0] d;
      rst_n   = 1'b0;
      flit_in = '0;
      defl_in = '0;

      // reset with traffic present
      vecs[0] = '{1'b0, f4(11'h401, 11'h402, 11'h403, 11'h404), 4'b1111,
                  44'h0, 3'd0, 1'b0, 1'b1, 1'b0};
      // first cycle after release passes flits unchanged
      vecs[1] = '{1'b1, f4(11'h401, 11'h402, 11'h403, 11'h404), 4'b0000,
                  f4(11'h401, 11'h402, 11'h403, 11'h404), 3'd0, 1'b0, 1'b1, 1'b0};
      // invalid flits are zeroed; defl on an invalid channel is ignored
      vecs[2] = '{1'b1, f4(11'h0AB, 11'h455, 11'h3FF, 11'h000), 4'b0001,
                  f4(11'h000, 11'h455, 11'h000, 11'h000), 3'd0, 1'b0, 1'b1, 1'b0};
      // east deflected flit is buffered
      vecs[3] = '{1'b1, f4(11'h421, 11'h000, 11'h000, 11'h000), 4'b0001,
                  44'h0, 3'd1, 1'b0, 1'b0, 1'b0};
      // head reinjected into the lowest empty slot
      vecs[4] = '{1'b1, 44'h0, 4'b0000,
                  f4(11'h421, 11'h000, 11'h000, 11'h000), 3'd0, 1'b0, 1'b1, 1'b0};
      // two candidates: only the lowest index is buffered
      vecs[5] = '{1'b1, f4(11'h430, 11'h431, 11'h000, 11'h000), 4'b0011,
                  f4(11'h000, 11'h431, 11'h000, 11'h000), 3'd1, 1'b0, 1'b0, 1'b0};
      // no free slot: head waits, traffic passes
      vecs[6] = '{1'b1, f4(11'h440, 11'h441, 11'h442, 11'h443), 4'b0000,
                  f4(11'h440, 11'h441, 11'h442, 11'h443), 3'd1, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{1'b1, 44'h0, 4'b0000,
                  f4(11'h430, 11'h000, 11'h000, 11'h000), 3'd0, 1'b0, 1'b1, 1'b0};

      for (int i = 0; i < 8; i++) begin
         apply($sformatf("vec%0d", i), vecs[i].r, vecs[i].fin, vecs[i].defl,
               vecs[i].exp_out, vecs[i].exp_cnt, vecs[i].exp_full,
               vecs[i].exp_empty, vecs[i].exp_starve);
      end

      // Fill to full; the other channels stay valid so nothing is reinjected.
      for (int k = 0; k < 4; k++) begin
         d = 11'h501 + 11'(k);
         apply($sformatf("fill%0d", k), 1'b1, f4(d, 11'h601, 11'h602, 11'h603), 4'b0001,
               f4(11'h000, 11'h601, 11'h602, 11'h603), 3'(k + 1), (k == 3), 1'b0, 1'b0);
      end
      // Full: head to the free north slot while west is buffered
      apply("full_swap", 1'b1, f4(11'h610, 11'h40C, 11'h000, 11'h611), 4'b0010,
            f4(11'h610, 11'h000, 11'h501, 11'h611), 3'd4, 1'b1, 1'b0, 1'b0);
      // Full, no free slot: all candidates stay deflected
      apply("full_pass", 1'b1, f4(11'h620, 11'h621, 11'h622, 11'h623), 4'b1111,
            f4(11'h620, 11'h621, 11'h622, 11'h623), 3'd4, 1'b1, 1'b0, 1'b0);
      // Drain: FIFO order preserved, west flit last
      apply("drain0", 1'b1, 44'h0, 4'b0000, f4(11'h502, 0, 0, 0), 3'd3, 1'b0, 1'b0, 1'b0);
      apply("drain1", 1'b1, 44'h0, 4'b0000, f4(11'h503, 0, 0, 0), 3'd2, 1'b0, 1'b0, 1'b0);
      apply("drain2", 1'b1, 44'h0, 4'b0000, f4(11'h504, 0, 0, 0), 3'd1, 1'b0, 1'b0, 1'b0);
      apply("drain3", 1'b1, 44'h0, 4'b0000, f4(11'h40C, 0, 0, 0), 3'd0, 1'b0, 1'b1, 1'b0);

      // Starvation: one entry buffered, then eight fully occupied cycles
      apply("stv_push", 1'b1, f4(11'h421, 0, 0, 0), 4'b0001, 44'h0, 3'd1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < STARVE; k++) begin
         d = 11'h4A0 + 11'(k);
         apply($sformatf("stv_wait%0d", k), 1'b1, f4(d, 11'h7A1, 11'h7A2, 11'h7A3), 4'b0000,
               f4(d, 11'h7A1, 11'h7A2, 11'h7A3), 3'd1, 1'b0, 1'b0, 1'b0);
      end
      apply("stv_swap", 1'b1, f4(11'h4E1, 11'h7B1, 11'h7B2, 11'h7B3), 4'b0000,
            f4(11'h421, 11'h7B1, 11'h7B2, 11'h7B3), 3'd1, 1'b0, 1'b0, 1'b1);
      // Counter cleared by the swap: a fully occupied cycle does not swap again
      apply("stv_after", 1'b1, f4(11'h4F0, 11'h7C1, 11'h7C2, 11'h7C3), 4'b0000,
            f4(11'h4F0, 11'h7C1, 11'h7C2, 11'h7C3), 3'd1, 1'b0, 1'b0, 1'b0);
      apply("stv_drain", 1'b1, 44'h0, 4'b0000, f4(11'h4E1, 0, 0, 0), 3'd0, 1'b0, 1'b1, 1'b0);

      // Pointer wrap: ten push/pop alternations
      for (int k = 0; k < 10; k++) begin
         d = 11'h480 + 11'(k);
         apply($sformatf("wrap_push%0d", k), 1'b1, f4(d, 11'h601, 11'h602, 11'h603), 4'b0001,
               f4(11'h000, 11'h601, 11'h602, 11'h603), 3'd1, 1'b0, 1'b0, 1'b0);
         apply($sformatf("wrap_pop%0d", k), 1'b1, 44'h0, 4'b0000,
               f4(d, 0, 0, 0), 3'd0, 1'b0, 1'b1, 1'b0);
      end

      // Reset mid-operation discards buffered flits
      apply("rst_push0", 1'b1, f4(11'h511, 11'h601, 11'h602, 11'h603), 4'b0001,
            f4(11'h000, 11'h601, 11'h602, 11'h603), 3'd1, 1'b0, 1'b0, 1'b0);
      apply("rst_push1", 1'b1, f4(11'h512, 11'h601, 11'h602, 11'h603), 4'b0001,
            f4(11'h000, 11'h601, 11'h602, 11'h603), 3'd2, 1'b0, 1'b0, 1'b0);
      apply("rst_mid", 1'b0, f4(11'h401, 11'h402, 11'h403, 11'h404), 4'b1111,
            44'h0, 3'd0, 1'b0, 1'b1, 1'b0);
      apply("rst_after", 1'b1, 44'h0, 4'b0000, 44'h0, 3'd0, 1'b0, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
